// File: rtl/flappy_game_ctrl.sv
// Game sequencer for the pipe X-coordinate store. It turns the flap and collide inputs into
// Start/Stop/Ack handshakes, generates the scroll tick and keeps the session best score.
module flappy_game_ctrl #(
    parameter int unsigned TICK_DIV  = 416667,
    parameter int unsigned OVER_HOLD = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flap,
    input  logic       collide,
    input  logic       ram_q_initial,
    input  logic       ram_q_count,
    input  logic       ram_q_stop,
    input  logic [3:0] ram_score,
    output logic       ram_start,
    output logic       ram_stop,
    output logic       ram_ack,
    output logic       scroll_en,
    output logic [3:0] best_score,
    output logic       game_over,
    output logic       q_idle,
    output logic       q_run,
    output logic       q_over
);

    localparam int unsigned TICK_W  = 20;
    localparam int unsigned HOLD_W  = 26;
    localparam int unsigned SCORE_W = 4;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_LAUNCH = 6'b000010,
        S_RUN    = 6'b000100,
        S_HALT   = 6'b001000,
        S_OVER   = 6'b010000,
        S_ACK    = 6'b100000
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                flap_d;
    logic                flap_rise;
    logic [TICK_W-1:0]   tick_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                tick_term;
    logic                hold_done;

    assign flap_rise = flap & ~flap_d;
    assign tick_term = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign hold_done = (hold_cnt == HOLD_W'(OVER_HOLD));

    // State register and flap edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            flap_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            flap_d <= flap;
        end
    end

    // Scroll divider: cleared in idle, runs only while playing, frozen elsewhere
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (state == S_IDLE) begin
            tick_cnt <= '0;
        end else if (state == S_RUN) begin
            if (tick_term) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    // Game-over hold timer, saturating so a late flap is always accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (state == S_HALT) begin
            hold_cnt <= '0;
        end else if ((state == S_OVER) && !hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Best score updates on the cycle the store confirms the stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_score <= '0;
        end else if ((state == S_HALT) && ram_q_stop && (ram_score > best_score)) begin
            best_score <= SCORE_W'(ram_score);
        end
    end

    // Next state and handshake decode
    always_comb begin
        state_nxt = state;
        ram_start = 1'b0;
        ram_stop  = 1'b0;
        ram_ack   = 1'b0;
        scroll_en = 1'b0;
        game_over = 1'b0;
        case (state)
            S_IDLE: begin
                if (flap_rise) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                ram_start = 1'b1;
                if (ram_q_count) state_nxt = S_RUN;
            end
            S_RUN: begin
                // A collision on the terminal count freezes the pipes on the fatal frame
                scroll_en = tick_term & ~collide;
                if (collide) state_nxt = S_HALT;
            end
            S_HALT: begin
                ram_stop = 1'b1;
                if (ram_q_stop) state_nxt = S_OVER;
            end
            S_OVER: begin
                game_over = 1'b1;
                if (hold_done && flap_rise) state_nxt = S_ACK;
            end
            S_ACK: begin
                game_over = 1'b1;
                ram_ack   = 1'b1;
                if (ram_q_initial) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset itself holds the idle indicator low so every output reads zero during reset
    assign q_idle = reset & (state == S_IDLE);
    assign q_run  = (state == S_RUN);
    assign q_over = (state == S_OVER) | (state == S_ACK);

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: expected values are queued at stimulus time
// and popped when the corresponding DUT output is sampled.
module tb_flappy_game_ctrl;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned OVER_HOLD = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       flap;
    logic       collide;
    logic       ram_q_initial;
    logic       ram_q_count;
    logic       ram_q_stop;
    logic [3:0] ram_score;
    logic       ram_start;
    logic       ram_stop;
    logic       ram_ack;
    logic       scroll_en;
    logic [3:0] best_score;
    logic       game_over;
    logic       q_idle;
    logic       q_run;
    logic       q_over;

    int         checks = 0;
    int         errors = 0;
    int         launches;
    logic       prev_start;

    string      tag_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    flappy_game_ctrl #(
        .TICK_DIV (TICK_DIV),
        .OVER_HOLD(OVER_HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flap         (flap),
        .collide      (collide),
        .ram_q_initial(ram_q_initial),
        .ram_q_count  (ram_q_count),
        .ram_q_stop   (ram_q_stop),
        .ram_score    (ram_score),
        .ram_start    (ram_start),
        .ram_stop     (ram_stop),
        .ram_ack      (ram_ack),
        .scroll_en    (scroll_en),
        .best_score   (best_score),
        .game_over    (game_over),
        .q_idle       (q_idle),
        .q_run        (q_run),
        .q_over       (q_over)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [7:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check_val(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] e, input logic [7:0] obs);
        expect_val(tag, e);
        check_val(obs);
    endtask

    initial begin
        reset = 1'b0; flap = 1'b0; collide = 1'b0; ram_q_initial = 1'b0;
        ram_q_count = 1'b0; ram_q_stop = 1'b0; ram_score = 4'd0;
        tick(); tick(); settle();
        chk("rst_q_idle", 8'd0, 8'(q_idle));
        chk("rst_best", 8'd0, 8'(best_score));
        chk("rst_outs", 8'd0, 8'({ram_start, ram_stop, ram_ack, scroll_en, game_over, q_run, q_over}));
        reset = 1'b1; settle();
        chk("idle_after_rst", 8'd1, 8'(q_idle));
        tick();

        // Launch handshake and scroll cadence
        flap = 1'b1; tick(); flap = 1'b0; settle();
        chk("launch_start", 8'd1, 8'(ram_start));
        chk("launch_not_idle", 8'd0, 8'(q_idle));
        tick(); tick(); settle();
        chk("launch_hold_start", 8'd1, 8'(ram_start));
        ram_q_count = 1'b1; settle();
        chk("launch_wait_run", 8'd0, 8'(q_run));
        tick(); ram_q_count = 1'b0; settle();
        chk("run_entry", 8'd1, 8'(q_run));
        chk("run_start_low", 8'd0, 8'(ram_start));
        for (int k = 1; k <= 12; k++) expect_val("scroll_cadence", 8'((k % 4) == 0));
        for (int k = 1; k <= 12; k++) begin
            check_val(8'(scroll_en));
            tick(); settle();
        end

        // Collision on the terminal count
        tick(); tick(); tick();
        collide = 1'b1; settle();
        chk("collide_tick_suppressed", 8'd0, 8'(scroll_en));
        chk("collide_still_run", 8'd1, 8'(q_run));
        tick(); collide = 1'b0; settle();
        chk("halt_stop", 8'd1, 8'(ram_stop));
        chk("halt_scroll_low", 8'd0, 8'(scroll_en));
        chk("halt_not_run", 8'd0, 8'(q_run));

        // Stop confirmation and best score
        ram_score = 4'd7; ram_q_stop = 1'b1; settle();
        chk("halt_stop_until_ack", 8'd1, 8'(ram_stop));
        tick(); ram_q_stop = 1'b0; settle();
        chk("best_7", 8'd7, 8'(best_score));
        chk("over_game_over", 8'd1, 8'(game_over));
        chk("over_stop_low", 8'd0, 8'(ram_stop));
        chk("over_q_over", 8'd1, 8'(q_over));

        // Game-over hold window
        repeat (4) tick();
        flap = 1'b1; tick(); flap = 1'b0; settle();
        chk("early_flap_ignored", 8'd0, 8'(ram_ack));
        chk("early_flap_still_over", 8'd1, 8'(q_over));
        repeat (6) tick();
        flap = 1'b1; settle();
        chk("ack_not_before_edge", 8'd0, 8'(ram_ack));
        tick(); flap = 1'b0; settle();
        chk("ack_raised", 8'd1, 8'(ram_ack));
        chk("ack_game_over", 8'd1, 8'(game_over));
        chk("ack_q_over", 8'd1, 8'(q_over));
        tick(); tick(); settle();
        chk("ack_held", 8'd1, 8'(ram_ack));
        ram_q_initial = 1'b1; tick(); ram_q_initial = 1'b0; settle();
        chk("back_idle", 8'd1, 8'(q_idle));
        chk("back_ack_low", 8'd0, 8'(ram_ack));
        chk("back_game_over_low", 8'd0, 8'(game_over));

        // Held flap gives a single launch; second game with a lower score
        launches = 0; prev_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            flap = 1'b1;
            ram_score = 4'd3;
            ram_q_count = (c == 3);
            collide = (c == 10);
            ram_q_stop = (c == 13);
            settle();
            if (ram_start && !prev_start) launches++;
            prev_start = ram_start;
            tick();
        end
        ram_q_count = 1'b0; collide = 1'b0; ram_q_stop = 1'b0; settle();
        chk("single_launch", 8'd1, 8'(launches));
        chk("held_flap_stays_over", 8'd1, 8'(q_over));
        chk("best_keeps_7", 8'd7, 8'(best_score));
        flap = 1'b0; tick();
        flap = 1'b1; tick(); settle();
        chk("second_ack", 8'd1, 8'(ram_ack));
        ram_q_initial = 1'b1; tick(); ram_q_initial = 1'b0;
        repeat (5) tick();
        settle();
        chk("held_idle", 8'd1, 8'(q_idle));
        chk("no_relaunch", 8'd0, 8'(ram_start));
        flap = 1'b0; tick();

        // Asynchronous reset in the middle of play
        flap = 1'b1; tick(); flap = 1'b0;
        ram_q_count = 1'b1; tick(); ram_q_count = 1'b0;
        tick(); tick(); tick(); settle();
        chk("pre_rst_scroll", 8'd1, 8'(scroll_en));
        chk("pre_rst_run", 8'd1, 8'(q_run));
        chk("pre_rst_best", 8'd7, 8'(best_score));
        reset = 1'b0; #1;
        chk("arst_scroll", 8'd0, 8'(scroll_en));
        chk("arst_run", 8'd0, 8'(q_run));
        chk("arst_best", 8'd0, 8'(best_score));
        chk("arst_outs", 8'd0, 8'({ram_start, ram_stop, ram_ack, game_over, q_idle, q_over}));
        tick(); reset = 1'b1; settle();
        chk("post_rst_idle", 8'd1, 8'(q_idle));
        chk("post_rst_best", 8'd0, 8'(best_score));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Top-level sequencer for the pipe X-coordinate store.
- Converts the player's flap button and the obstacle logic's collision flag into the store's Start/Stop/Ack handshakes.
- Generates the frame-rate scroll tick that gates the store's clock enable.
- Tracks the session best score.
- Sits between the button/debounce logic, the obstacle/collision logic and the pipe X store.

Parameters:
- TICK_DIV, 416667, clk cycles per scroll tick (25 MHz / 60 Hz); legal range 2..2^20-1.
- OVER_HOLD, 25000000, clk cycles the game-over screen is held before a flap may restart; legal range 1..2^26-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- flap  in  1  debounced, synchronous flap button level.
- collide  in  1  collision flag from the obstacle logic, sampled every cycle.
- ram_q_initial  in  1  X store state flag: Initial.
- ram_q_count  in  1  X store state flag: Count.
- ram_q_stop  in  1  X store state flag: Stop.
- ram_score  in  4  X store pipe-pass score.
- ram_start  out  1  Start request to the X store.
- ram_stop  out  1  Stop request to the X store.
- ram_ack  out  1  Ack to the X store.
- scroll_en  out  1  one-cycle scroll tick; gates the X store enable and the bird physics.
- best_score  out  4  highest ram_score latched since reset.
- game_over  out  1  high in QOver.
- q_idle, q_run, q_over  out  1 each  one-hot state visibility for the display logic.

Behaviour:
- States, one-hot:
  - QIdle, QLaunch, QRun, QHalt, QOver.
  - An illegal encoding returns to QIdle on the next clk.
- While reset=0:
  - state=QIdle; tick and hold counters = 0; flap_d=0.
  - All outputs = 0, including best_score=0.
- Flap edge: flap_rise = flap & ~flap_d, where flap_d is a 1-cycle registered copy of flap. A held button produces exactly one edge.
- QIdle:
  - flap_rise -> QLaunch.
  - Tick counter cleared.
- QLaunch:
  - ram_start=1 combinationally for the whole state.
  - When ram_q_count=1 -> QRun; ram_start falls in the same cycle the state leaves.
  - No timeout.
- QRun:
  - Tick counter increments each cycle. At TICK_DIV-1 it wraps to 0 and scroll_en=1 for that one cycle. First tick occurs TICK_DIV cycles after entering QRun.
  - collide=1 -> QHalt next cycle.
  - If collide and the tick terminal count coincide, scroll_en is suppressed (collision wins; pipes do not move on the fatal frame).
  - Tick counter frozen outside QRun.
- QHalt:
  - ram_stop=1 until ram_q_stop=1.
  - On that cycle: -> QOver, and best_score <= ram_score if ram_score > best_score (unsigned 4-bit compare).
  - Hold counter cleared.
- QOver:
  - game_over=1.
  - Hold counter increments, saturating at OVER_HOLD.
  - flap_rise is ignored until the counter reaches OVER_HOLD.
  - After that, flap_rise -> QAck.
- QAck (sub-phase of QOver encoding, exposes q_over=1):
  - ram_ack=1 until ram_q_initial=1, then -> QIdle.
  - collide is ignored.
- Output exclusivity: at most one of ram_start/ram_stop/ram_ack is high in any cycle. scroll_en is 0 outside QRun.
- best_score is retained across games and cleared only by reset. ram_score wrap past 15 is not extended.
- Reset mid-game: all state returns to reset values immediately (asynchronous). The X store is reset by the same line.

Test Plan:
1. Release reset, pulse flap 1 cycle -> ram_start=1 next cycle; drive ram_q_count=1 after 3 cycles -> q_run=1, ram_start=0; with TICK_DIV=4, scroll_en pulses at cycles 4, 8 and 12 after QRun entry.
2. In QRun, assert collide on the same cycle as tick terminal count -> scroll_en=0 that cycle; ram_stop=1 next cycle.
3. Set ram_score=7, ram_q_stop=1 -> best_score=7, game_over=1. Next game ram_score=3 -> best_score stays 7.
4. OVER_HOLD=10: flap pulse at cycle 5 of QOver -> ignored. Flap at cycle 12 -> ram_ack=1 until ram_q_initial=1 -> q_idle=1.
5. Hold flap high for 50 cycles in QIdle -> exactly one QLaunch entry, and no relaunch after returning to QIdle while flap is still held.
6. Drop reset during QRun -> scroll_en, ram_* and q_run go to 0 asynchronously; best_score=0; state=QIdle after release.
